seg_scan_ctrl: RTL and testbench

//   Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment display. One

---
 rtl/seg_scan_ctrl.sv | 104 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// The displayed value is double-buffered and swapped only at frame boundaries.
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 4,
  parameter int BLANK  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  lz_en,
  output logic [3:0]            nibble,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end;
  logic                  frame_end;
  logic                  blanked;
  logic                  upper_zero;
  logic [DIGITS-1:0]     supp;

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = frame_end ? '0 : idx_q + 1'b1;
    end

    disp_d    = disp_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    // A load landing on the frame end goes straight to disp, skipping the shadow.
    if (frame_end) begin
      if (load) begin
        disp_d = data_in;
      end else if (pending_q) begin
        disp_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end

    frame_done_d = frame_end;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Walk from the MSD down: a digit is dark while every nibble at or above it is zero.
  always_comb begin
    upper_zero = 1'b1;
    supp       = '0;
    for (int unsigned i = 0; i < DIGITS - 1; i++) begin
      upper_zero = upper_zero & (disp_q[4*(DIGITS-1-i) +: 4] == 4'h0);
      supp[DIGITS-1-i] = lz_en & upper_zero;
    end
  end

  always_comb begin
    blanked = int'(cnt_q) < BLANK;
    nibble  = disp_q[4*idx_q +: 4];
    an      = '0;
    if (!blanked && !supp[idx_q]) begin
      an[idx_q] = 1'b1;
    end
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: cycle-count reference model plus
// a second fast-scan instance with no blanking.
module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int BLANK  = 1;
  localparam int FR     = DIGITS * DIV;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load, lz_en;
  logic [15:0] data_in;
  logic [3:0]  nibble, an;
  logic        frame_done;

  logic        reset2, load2, lz_en2;
  logic [15:0] data_in2;
  logic [3:0]  nibble2, an2;
  logic        frame_done2;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in), .lz_en(lz_en),
    .nibble(nibble), .an(an), .frame_done(frame_done)
  );

  seg_scan_ctrl #(.DIGITS(4), .DIV(2), .BLANK(0)) dut_fast (
    .clk(clk), .reset(reset2), .load(load2), .data_in(data_in2), .lz_en(lz_en2),
    .nibble(nibble2), .an(an2), .frame_done(frame_done2)
  );

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  // Reference model: m_t counts clock edges since reset release.
  int unsigned m_t;
  logic [15:0] m_disp, m_shadow;
  logic        m_pend, m_fd;

  function automatic int unsigned cur_idx();
    return (m_t / DIV) % DIGITS;
  endfunction

  function automatic int unsigned cur_cnt();
    return m_t % DIV;
  endfunction

  function automatic logic [3:0] exp_nibble();
    logic [15:0] s;
    s = m_disp >> (4 * cur_idx());
    return s[3:0];
  endfunction

  function automatic logic [3:0] exp_an();
    if (cur_cnt() < BLANK) return 4'b0000;
    if (lz_en && cur_idx() != 0 && (m_disp >> (4 * cur_idx())) == 16'h0) return 4'b0000;
    return 4'(1 << cur_idx());
  endfunction

  task automatic model_reset();
    m_t = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0; m_fd = 1'b0;
  endtask

  task automatic step();
    logic fe;
    @(posedge clk);
    if (!reset) begin
      fe = (m_t % FR) == FR - 1;
      if (fe) begin
        if (load) m_disp = data_in;
        else if (m_pend) m_disp = m_shadow;
        m_pend = 1'b0;
      end else if (load) begin
        m_shadow = data_in;
        m_pend   = 1'b1;
      end
      m_fd = fe;
      m_t++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; data_in = '0; lz_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (an !== 4'b0000) $display("FAIL reset_an: got %b expected 0000", an); else pass_cnt++;
    chk_cnt++; if (nibble !== 4'h0) $display("FAIL reset_nibble: got %h expected 0", nibble); else pass_cnt++;
    chk_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_fd: got %b expected 0", frame_done); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_first_frame();
    lz_en = 1'b1;
    data_in = 16'h1234;
    for (int c = 0; c < 2 * FR; c++) begin
      load = (m_t == 3);
      step();
      load = 1'b0;
      chk_cnt++;
      if ({frame_done, an, nibble} !== {m_fd, exp_an(), exp_nibble()})
        $display("FAIL first_scan t=%0d: got %h expected %h", m_t, {frame_done, an, nibble}, {m_fd, exp_an(), exp_nibble()});
      else pass_cnt++;
      if (m_t == 16) begin
        chk_cnt++; if (frame_done !== 1'b1) $display("FAIL fd_at_16: got %b expected 1", frame_done); else pass_cnt++;
      end
      if (m_t == FR + 1) begin
        chk_cnt++;
        if ({an, nibble} !== {4'b0001, 4'h4}) $display("FAIL f2_slot0: got %h expected 14", {an, nibble}); else pass_cnt++;
      end
      if (m_t == FR + 3 * DIV + 2) begin
        chk_cnt++;
        if ({an, nibble} !== {4'b1000, 4'h1}) $display("FAIL f2_slot3: got %h expected 81", {an, nibble}); else pass_cnt++;
      end
    end
  endtask

  task automatic test_last_wins();
    logic seen_a;
    seen_a = 1'b0;
    lz_en = 1'b0;
    for (int c = 0; c < 2 * FR; c++) begin
      load = (c == 2) || (c == 9);
      data_in = (c == 2) ? 16'hAAAA : 16'h5555;
      step();
      load = 1'b0;
      if (nibble === 4'hA) seen_a = 1'b1;
      chk_cnt++;
      if ({frame_done, an, nibble} !== {m_fd, exp_an(), exp_nibble()})
        $display("FAIL lastwins_scan t=%0d: got %h expected %h", m_t, {frame_done, an, nibble}, {m_fd, exp_an(), exp_nibble()});
      else pass_cnt++;
    end
    chk_cnt++; if (seen_a !== 1'b0) $display("FAIL lastwins_no_A: got %b expected 0", seen_a); else pass_cnt++;
    chk_cnt++; if (nibble !== 4'h5) $display("FAIL lastwins_val: got %h expected 5", nibble); else pass_cnt++;
  endtask

  task automatic test_frame_end_load();
    lz_en = 1'b0;
    for (int c = 0; c < 3 * FR; c++) begin
      load = (c == 5) || (c == FR - 1);
      data_in = (c == 5) ? 16'h1111 : 16'h00F0;
      step();
      load = 1'b0;
      chk_cnt++;
      if ({frame_done, an, nibble} !== {m_fd, exp_an(), exp_nibble()})
        $display("FAIL fe_scan t=%0d: got %h expected %h", m_t, {frame_done, an, nibble}, {m_fd, exp_an(), exp_nibble()});
      else pass_cnt++;
      if (c == FR + DIV || c == 2 * FR + DIV) begin
        chk_cnt++;
        if ({an, nibble} !== {4'b0010, 4'hF}) $display("FAIL fe_digit1 c=%0d: got %h expected 2f", c, {an, nibble}); else pass_cnt++;
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [4];
    logic [3:0]  masks [4];
    logic [3:0]  lit;
    vals[0] = 16'h0007; masks[0] = 4'b0001;
    vals[1] = 16'h0000; masks[1] = 4'b0001;
    vals[2] = 16'h0100; masks[2] = 4'b0111;
    vals[3] = 16'h3000; masks[3] = 4'b1111;
    lz_en = 1'b1;
    for (int v = 0; v < 4; v++) begin
      lit = '0;
      for (int c = 0; c < 2 * FR; c++) begin
        load = (c == 0);
        data_in = vals[v];
        step();
        load = 1'b0;
        if (c >= FR) lit = lit | an;
        chk_cnt++;
        if ({frame_done, an, nibble} !== {m_fd, exp_an(), exp_nibble()})
          $display("FAIL lz_scan t=%0d: got %h expected %h", m_t, {frame_done, an, nibble}, {m_fd, exp_an(), exp_nibble()});
        else pass_cnt++;
      end
      chk_cnt++;
      if (lit !== masks[v]) $display("FAIL lz_mask %h: got %b expected %b", vals[v], lit, masks[v]); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [15:0] masks [4];
    masks[0] = 16'h000F; masks[1] = 16'h00FF; masks[2] = 16'h0FFF; masks[3] = 16'hFFFF;
    for (int c = 0; c < 20 * FR; c++) begin
      load    = ($urandom_range(0, 5) == 0);
      data_in = 16'($urandom) & masks[$urandom_range(0, 3)];
      lz_en   = 1'($urandom);
      step();
      load = 1'b0;
      chk_cnt++;
      if ({frame_done, an, nibble} !== {m_fd, exp_an(), exp_nibble()})
        $display("FAIL rand_scan t=%0d: got %h expected %h", m_t, {frame_done, an, nibble}, {m_fd, exp_an(), exp_nibble()});
      else pass_cnt++;
    end
    lz_en = 1'b0;
  endtask

  task automatic test_reset_midslot();
    logic hit;
    hit = 1'b0;
    lz_en = 1'b0;
    for (int c = 0; c < FR; c++) begin
      load = (c == 1);
      data_in = 16'h9876;
      step();
      load = 1'b0;
    end
    for (int c = 0; c < FR; c++) begin
      load = (c == 3);
      data_in = 16'h4321;
      step();
      load = 1'b0;
      if (m_t % FR == 2 * DIV + 2) begin
        hit = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (hit !== 1'b1 || {an, nibble} !== {4'b0100, 4'h8})
      $display("FAIL midslot_pre: got %h expected 48", {an, nibble});
    else pass_cnt++;
    reset = 1'b1;
    #1;
    chk_cnt++; if (an !== 4'b0000) $display("FAIL midslot_an: got %b expected 0000", an); else pass_cnt++;
    chk_cnt++; if (nibble !== 4'h0) $display("FAIL midslot_nibble: got %h expected 0", nibble); else pass_cnt++;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2 * FR; c++) begin
      step();
      chk_cnt++;
      if ({frame_done, an, nibble} !== {m_fd, exp_an(), exp_nibble()})
        $display("FAIL midslot_scan t=%0d: got %h expected %h", m_t, {frame_done, an, nibble}, {m_fd, exp_an(), exp_nibble()});
      else pass_cnt++;
    end
  endtask

  task automatic test_fast_scan();
    int unsigned lit [4];
    for (int k = 0; k < 4; k++) lit[k] = 0;
    @(negedge clk);
    reset2 = 1'b0;
    for (int t2 = 1; t2 <= 16; t2++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (an2[k] === 1'b1) lit[k]++;
      chk_cnt++;
      if (an2 !== 4'(1 << ((t2 / 2) % 4))) $display("FAIL fast_an t=%0d: got %b expected %b", t2, an2, 4'(1 << ((t2 / 2) % 4)));
      else pass_cnt++;
      chk_cnt++;
      if (frame_done2 !== 1'(t2 % 8 == 0)) $display("FAIL fast_fd t=%0d: got %b expected %b", t2, frame_done2, 1'(t2 % 8 == 0));
      else pass_cnt++;
    end
    for (int k = 0; k < 4; k++) begin
      chk_cnt++;
      if (lit[k] != 4) $display("FAIL fast_lit d%0d: got %0d expected 4", k, lit[k]); else pass_cnt++;
    end
  endtask

  initial begin
    reset2 = 1'b1; load2 = 1'b0; data_in2 = '0; lz_en2 = 1'b0;
    test_reset();
    test_first_frame();
    test_last_wins();
    test_frame_end_load();
    test_lz();
    test_random();
    test_reset_midslot();
    test_fast_scan();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
